bus: RTL and testbench
======================

Name: bus

Overview:
- Shared-bus interconnect for NUM_PROC cache controllers.
- Each processor port posts a one-cycle request carrying a destination: another processor's cache, or main memory (index NUM_PROC).
- Pending requests are latched, arbitrated round-robin, and hold the bus for a destination-dependent latency; the requester is then notified through request_avail.
- Sits between the per-processor cache controllers and the memory model.

Parameters:
- NUM_PROC, 4, number of processor ports; destination index NUM_PROC means memory.
- MEM_LATENCY, 4, bus-occupancy cycles for a memory destination (minimum 1).
- C2C_LATENCY, 2, bus-occupancy cycles for a processor (cache-to-cache) destination (minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_l  input  1  asynchronous active-low reset.
- request  input  NUM_PROC  per-port request strobe, sampled at each rising edge.
- request_dest  input  NUM_PROC x ($clog2(NUM_PROC)+1)  per-port destination; 0..NUM_PROC-1 is a processor, NUM_PROC is memory.
- processed_request  output  1  one-cycle pulse: a request was granted the bus.
- request_avail  output  NUM_PROC  one-hot one-cycle pulse: that port's transaction completed.

Behaviour:
- Reset (rst_l=0, asynchronous):
  - pending, dest registers and counter cleared.
  - State IDLE; last_grant = NUM_PROC-1, so port 0 has first priority.
  - processed_request=0, request_avail=0.
- Capture:
  - At an edge with request[i]=1 and pending[i]=0: set pending[i] and latch dest[i]=request_dest[i].
  - request[i] while pending[i]=1 is ignored, including at the edge where port i completes.
  - Requesters need only a one-cycle strobe.
- Destination decode:
  - dest == NUM_PROC, or any value above NUM_PROC: memory, latency MEM_LATENCY.
  - dest < NUM_PROC, including dest equal to the source port: cache-to-cache, latency C2C_LATENCY.
- State machine, IDLE / BUSY:
  - IDLE with any pending bit at an edge:
    - Grant the first pending port searching from last_grant+1 upward, wrapping modulo NUM_PROC.
    - Record owner, set last_grant=owner, load counter with latency-1, go to BUSY.
    - processed_request=1 for the following cycle.
  - A request captured at edge E can be granted no earlier than edge E+1; capture and grant never occur on the same edge.
  - BUSY, counter>0: decrement each edge.
  - BUSY, counter==0, at the next edge:
    - request_avail[owner]=1 for one cycle.
    - Clear pending[owner]; return to IDLE.
  - No grant happens on a completion edge; the next grant is at the following edge at the earliest.
- Timing:
  - Grant at edge G means request_avail is high in the cycle after edge G+L.
  - Example: MEM_LATENCY=4, captured at E0, granted at E1, request_avail[0] high after E5.
- Outputs are registered; all other output bits are 0 at all times.
- Reset mid-transaction aborts it silently: no request_avail pulse, all pending requests dropped.
- Only one transaction is in flight at a time. A port cannot have two outstanding requests.

Decomposition:
- Package bus_pkg:
  - typedef bus_state_t {IDLE, BUSY}.
  - Function for the destination width ($clog2(NUM_PROC)+1).
  - Function is_mem(dest, NUM_PROC).
- One natural sub-module, rr_arbiter:
  - Inputs: pending vector, last_grant.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational, parameterised by NUM_PROC.

Test Plan:
- Reset, then request[0]=1 with dest=4 for one cycle -> processed_request pulses the cycle after E1; request_avail=4'b0001 for exactly one cycle after E5; all other cycles 0.
- request[2]=1 with dest=1 -> request_avail=4'b0100 two edges after grant (C2C_LATENCY=2).
- All four ports request simultaneously with dest=4 after reset -> grant order 0,1,2,3, four processed_request pulses, request_avail pulses 5 edges apart, one-hot each.
- Port 1 re-requests while pending (dest=0, then dest=4) -> only the first transaction is served, with C2C latency; exactly one request_avail[1] pulse.
- Assert rst_l=0 asynchronously mid-BUSY -> outputs drop to 0 immediately; no completion pulse after release; a new request is then served normally.
- request_dest=7 (out of range) on port 3 -> treated as memory, MEM_LATENCY timing, request_avail=4'b1000.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus interconnect: FSM states and
// destination-field width / memory-destination decode.
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_t;

  function automatic int dest_w(input int num_proc);
    return $clog2(num_proc) + 1;
  endfunction

  // Anything at or above the processor count targets main memory.
  function automatic logic is_mem(input int dest, input int num_proc);
    return dest >= num_proc;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Combinational round-robin picker: first pending port after last_grant,
// wrapping modulo NUM_PROC.
module bus_rr_arbiter #(
  parameter int NUM_PROC = 4,
  parameter int IDX_W    = 2
) (
  input  logic [NUM_PROC-1:0] pending,
  input  logic [IDX_W-1:0]    last_grant,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx
);

  int idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_PROC; k++) begin
      idx = (int'(last_grant) + k) % NUM_PROC;
      if (!grant_valid && pending[IDX_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus.sv
// Shared-bus interconnect: latches one-cycle requests per port, grants them
// round-robin and holds the bus for a destination-dependent latency.
module bus
  import bus_pkg::*;
#(
  parameter int NUM_PROC    = 4,
  parameter int MEM_LATENCY = 4,
  parameter int C2C_LATENCY = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_l,
  input  logic [NUM_PROC-1:0]                   request,
  input  logic [NUM_PROC*dest_w(NUM_PROC)-1:0]  request_dest,
  output logic                                  processed_request,
  output logic [NUM_PROC-1:0]                   request_avail
);

  localparam int DW    = dest_w(NUM_PROC);
  localparam int IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int MAXL  = (MEM_LATENCY > C2C_LATENCY) ? MEM_LATENCY : C2C_LATENCY;
  localparam int CNT_W = $clog2(MAXL + 1);

  bus_state_t           state_q, state_d;
  logic [NUM_PROC-1:0]  pending_q, pending_d;
  logic [DW-1:0]        dest_q [NUM_PROC];
  logic [DW-1:0]        dest_d [NUM_PROC];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic                 proc_q, proc_d;
  logic [NUM_PROC-1:0]  avail_q, avail_d;

  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;

  // Arbitration only sees already-latched requests, so capture and grant
  // can never coincide on one edge.
  bus_rr_arbiter #(
    .NUM_PROC (NUM_PROC),
    .IDX_W    (IDX_W)
  ) u_arb (
    .pending     (pending_q),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    proc_d    = 1'b0;
    avail_d   = '0;

    for (int i = 0; i < NUM_PROC; i++) begin
      if (request[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        dest_d[i]    = request_dest[i*DW +: DW];
      end
    end

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          last_d  = grant_idx;
          cnt_d   = is_mem(int'(dest_q[grant_idx]), NUM_PROC)
                    ? CNT_W'(MEM_LATENCY - 1) : CNT_W'(C2C_LATENCY - 1);
          state_d = BUSY;
          proc_d  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          avail_d[owner_q]   = 1'b1;
          pending_d[owner_q] = 1'b0;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      pending_q <= '0;
      for (int i = 0; i < NUM_PROC; i++) dest_q[i] <= '0;
      cnt_q     <= '0;
      owner_q   <= '0;
      last_q    <= IDX_W'(NUM_PROC - 1);
      proc_q    <= 1'b0;
      avail_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      proc_q    <= proc_d;
      avail_q   <= avail_d;
    end
  end

  assign processed_request = proc_q;
  assign request_avail     = avail_q;

endmodule

// File: tb/tb_bus.sv
// Scoreboard bench for bus: stimulus pushes expected {processed_request,
// request_avail} per cycle; a negedge monitor compares every cycle.
module tb_bus;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [3:0]  request = '0;
  logic [11:0] request_dest = '0;
  logic        processed_request;
  logic [3:0]  request_avail;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e0;

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } exp_t;

  exp_t expq[$];

  bus #(.NUM_PROC(4), .MEM_LATENCY(4), .C2C_LATENCY(2)) dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .request           (request),
    .request_dest      (request_dest),
    .processed_request (processed_request),
    .request_avail     (request_avail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input logic g, input logic [3:0] a);
    exp_t e;
    e.cyc = c;
    e.val = {g, a};
    expq.push_back(e);
  endtask

  // Monitor: one comparison per cycle against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_l) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        e = expq.pop_front();
        chk("missed_event", 0, int'(e.val));
      end
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("bus_event", int'({processed_request, request_avail}), int'(e.val));
      end else begin
        chk("bus_idle", int'({processed_request, request_avail}), 0);
      end
    end
  end

  task automatic set_dest(input int port, input logic [2:0] d);
    request_dest[port*3 +: 3] = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() > 0) chk("drain_timeout", expq.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_proc", int'(processed_request), 0);
    chk("reset_avail", int'(request_avail), 0);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    // All four ports to memory: grants 0,1,2,3, completions 5 edges apart.
    e0 = cyc + 1;
    request = 4'b1111;
    for (int p = 0; p < 4; p++) set_dest(p, 3'd4);
    for (int k = 0; k < 4; k++) begin
      push(e0 + 1 + 5*k, 1'b1, 4'b0000);
      push(e0 + 5 + 5*k, 1'b0, 4'b0001 << k);
    end
    @(negedge clk);
    request = '0;
    drain();

    // Port 0 to memory.
    e0 = cyc + 1;
    request = 4'b0001;
    set_dest(0, 3'd4);
    push(e0 + 1, 1'b1, 4'b0000);
    push(e0 + 5, 1'b0, 4'b0001);
    @(negedge clk);
    request = '0;
    drain();

    // Port 2 cache-to-cache.
    e0 = cyc + 1;
    request = 4'b0100;
    set_dest(2, 3'd1);
    push(e0 + 1, 1'b1, 4'b0000);
    push(e0 + 3, 1'b0, 4'b0100);
    @(negedge clk);
    request = '0;
    drain();

    // Port 1 re-requests while pending, including on its completion edge.
    e0 = cyc + 1;
    request = 4'b0010;
    set_dest(1, 3'd0);
    push(e0 + 1, 1'b1, 4'b0000);
    push(e0 + 3, 1'b0, 4'b0010);
    @(negedge clk);
    set_dest(1, 3'd4);
    @(negedge clk);
    request = '0;
    @(negedge clk);
    request = 4'b0010;
    @(negedge clk);
    request = '0;
    drain();
    repeat (6) @(negedge clk);

    // Out-of-range destination is memory.
    e0 = cyc + 1;
    request = 4'b1000;
    set_dest(3, 3'd7);
    push(e0 + 1, 1'b1, 4'b0000);
    push(e0 + 5, 1'b0, 4'b1000);
    @(negedge clk);
    request = '0;
    drain();

    // Asynchronous reset while busy aborts silently.
    e0 = cyc + 1;
    request = 4'b0001;
    set_dest(0, 3'd4);
    push(e0 + 1, 1'b1, 4'b0000);
    @(negedge clk);
    request = '0;
    @(negedge clk);
    #1;
    chk("pre_reset_grant", int'(processed_request), 1);
    rst_l = 1'b0;
    expq.delete();
    #1;
    chk("async_reset_proc", int'(processed_request), 0);
    chk("async_reset_avail", int'(request_avail), 0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (8) @(negedge clk);

    e0 = cyc + 1;
    request = 4'b0001;
    set_dest(0, 3'd2);
    push(e0 + 1, 1'b1, 4'b0000);
    push(e0 + 3, 1'b0, 4'b0001);
    @(negedge clk);
    request = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
